// File: rtl/coa_pkg.sv
// Shared register-bank definitions: address/data widths, architectural register
// numbers and the write-back entry carried through the load-result FIFO.
package coa_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RET  = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for load results. Besides the head it exposes every slot in
// logical order (index 0 = oldest) with a valid mask so the top can forward from it.
module wb_fifo
  import coa_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid_mask
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers rely on DEPTH being a power of two so they wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    assign entries[i]    = mem[rd_ptr + PTR_W'(i)];
    assign valid_mask[i] = (CNT_W'(i) < count);
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and load results onto the register bank's single write port, with a
// starvation guard for queued loads and forwarding of all not-yet-visible results.
module reg_writeback_arbiter
  import coa_pkg::*;
#(
  parameter  int DEPTH      = 2,
  parameter  int STARVE_LIM = 4,
  localparam int CNT_W      = $clog2(DEPTH) + 1,
  localparam int SW         = $clog2(STARVE_LIM + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  rs_fwd_hit,
  output logic [DATA_W-1:0]     rs_fwd_data,
  output logic                  rt_fwd_hit,
  output logic [DATA_W-1:0]     rt_fwd_data,
  output logic [CNT_W-1:0]      pending
);

  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid_mask;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             sel_valid;
  wb_entry_t        sel_entry;
  logic [SW-1:0]    starve_cnt;

  // A pop in the same cycle never frees room for a push: ready looks at full only.
  assign mem_ready = !full;
  assign push      = mem_valid && !full;
  assign alu_stall = (starve_cnt >= SW'(STARVE_LIM)) && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{dest: mem_dest, data: mem_data}),
    .pop        (pop),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .count      (pending),
    .entries    (entries),
    .valid_mask (valid_mask)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    pop       = 1'b0;
    if (alu_stall) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_entry = head;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{dest: alu_dest, data: alu_data};
    end else if (!empty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_entry = head;
    end
  end

  // Results aimed at the zero register are consumed but never reach the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      reg_write <= sel_valid && (sel_entry.dest != REG_ZERO);
      if (sel_valid) begin
        write_reg  <= sel_entry.dest;
        write_data <= sel_entry.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt < SW'(STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  logic [REG_ADDR_W-1:0] fwd_addr [2];
  logic                  fwd_hit  [2];
  logic [DATA_W-1:0]     fwd_data [2];

  assign fwd_addr[0] = rs_addr;
  assign fwd_addr[1] = rt_addr;

  // Later (newer) FIFO matches override older ones; the output register overrides all.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      if (fwd_addr[p] != REG_ZERO) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_mask[i] && (entries[i].dest == fwd_addr[p])) begin
            fwd_hit[p]  = 1'b1;
            fwd_data[p] = entries[i].data;
          end
        end
        if (reg_write && (write_reg == fwd_addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = write_data;
        end
      end
    end
  end

  assign rs_fwd_hit  = fwd_hit[0];
  assign rs_fwd_data = fwd_data[0];
  assign rt_fwd_hit  = fwd_hit[1];
  assign rt_fwd_data = fwd_data[1];

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Scoreboard bench for reg_writeback_arbiter: a queue-based reference model predicts
// each cycle's bank write; a separate monitor compares the registered write port.
module tb_reg_writeback_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_fwd_hit;
  logic [31:0] rs_fwd_data;
  logic        rt_fwd_hit;
  logic [31:0] rt_fwd_data;
  logic [1:0]  pending;

  reg_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_fwd_hit(rs_fwd_hit), .rs_fwd_data(rs_fwd_data),
    .rt_fwd_hit(rt_fwd_hit), .rt_fwd_data(rt_fwd_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } res_t;

  typedef struct {
    bit          v;
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  int   n_vec = 0;
  int   n_err = 0;
  res_t mq[$];          // loads waiting, oldest first
  wr_t  exp_q[$];       // expected bank writes, one per modelled cycle
  int   head_wait = 0;  // cycles the current oldest load has been passed over
  wr_t  last_wr = '{v: 1'b0, dest: 5'd0, data: 32'd0};
  bit   last_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void fwd_model(input logic [4:0] a, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (a != 5'd0) begin
      foreach (mq[i]) if (mq[i].dest == a) begin hit = 1'b1; d = mq[i].data; end
      if (last_wr.v && last_wr.dest == a) begin hit = 1'b1; d = last_wr.data; end
    end
  endfunction

  task automatic cycle(input bit r, input bit av, input logic [4:0] ad, input logic [31:0] adt,
                       input bit mv, input logic [4:0] md, input logic [31:0] mdt,
                       input logic [4:0] a_rs, input logic [4:0] a_rt);
    bit          e_ready, e_stall, h;
    logic [31:0] d;
    wr_t         w;
    rst = r; alu_valid = av; alu_dest = ad; alu_data = adt;
    mem_valid = mv; mem_dest = md; mem_data = mdt; rs_addr = a_rs; rt_addr = a_rt;
    @(negedge clk);
    e_ready = (mq.size() < DEPTH);
    e_stall = (head_wait >= STARVE_LIM) && (mq.size() > 0);
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, e_ready});
    chk("alu_stall", {31'd0, alu_stall}, {31'd0, e_stall});
    chk("pending", {30'd0, pending}, mq.size());
    fwd_model(a_rs, h, d);
    chk("rs_fwd_hit", {31'd0, rs_fwd_hit}, {31'd0, h});
    chk("rs_fwd_data", rs_fwd_data, d);
    fwd_model(a_rt, h, d);
    chk("rt_fwd_hit", {31'd0, rt_fwd_hit}, {31'd0, h});
    chk("rt_fwd_data", rt_fwd_data, d);
    w = '{v: 1'b0, dest: 5'd0, data: 32'd0};
    if (r) begin
      mq.delete();
      head_wait = 0;
      e_stall   = 1'b0;
    end else begin
      bit   popped = 1'b0;
      bit   was_empty = (mq.size() == 0);
      res_t s;
      bit   have = 1'b0;
      if (e_stall || (!av && !was_empty)) begin
        s = mq.pop_front(); popped = 1'b1; have = 1'b1;
      end else if (av) begin
        s = '{dest: ad, data: adt}; have = 1'b1;
      end
      if (have && s.dest != 5'd0) w = '{v: 1'b1, dest: s.dest, data: s.data};
      if (was_empty || popped) head_wait = 0;
      else if (head_wait < STARVE_LIM) head_wait++;
      if (mv && e_ready) mq.push_back('{dest: md, data: mdt});
    end
    last_stall = e_stall;
    exp_q.push_back(w);
    last_wr = w;
    @(posedge clk);
    #1;
  endtask

  // Monitor: the write selected in a cycle is visible on the port after that cycle's edge.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reg_write", {31'd0, reg_write}, {31'd0, e.v});
        if (e.v) begin
          chk("write_reg", {27'd0, write_reg}, {27'd0, e.dest});
          chk("write_data", write_data, e.data);
        end
      end
    end
  end

  // Random phase; an ALU result stalled in one cycle is re-offered unchanged the next.
  task automatic run_phase(input int n, input int pa, input int pm, input int dmax, input int prst);
    bit          av = 1'b0;
    logic [4:0]  ad = 5'd0;
    logic [31:0] adt = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (!last_stall) begin
        av  = ($urandom_range(0, 99) < pa);
        ad  = 5'($urandom_range(0, dmax));
        adt = $urandom;
      end
      cycle(($urandom_range(0, 999) < prst), av, ad, adt,
            ($urandom_range(0, 99) < pm), 5'($urandom_range(0, dmax)), $urandom,
            5'($urandom_range(0, dmax)), 5'($urandom_range(0, dmax)));
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1; alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0; rs_addr = '0; rt_addr = '0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 5, 3);
    cycle(0, 0, 0, 0, 0, 0, 0, 5, 3);
    // ALU only, then forward from the output register
    cycle(0, 1, 5, 32'h1234, 0, 0, 0, 5, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 5, 4);
    // load and ALU collide; the load is forwarded from the FIFO meanwhile
    cycle(0, 1, 4, 32'hBB, 1, 3, 32'hAA, 3, 4);
    cycle(0, 0, 0, 0, 0, 0, 0, 3, 4);
    cycle(0, 0, 0, 0, 0, 0, 0, 3, 4);
    // fill with ALU busy, then let starvation drain it
    for (int k = 0; k < 12; k++)
      cycle(0, 1, 5'(8 + k % 8), 32'h100 + k, (k < 4), 5'(16 + k), 32'h200 + k, 5'(16 + k % 3), 5'(8 + k % 8));
    // dest 0 and reset with two loads pending
    cycle(0, 1, 0, 32'hFF, 0, 0, 0, 0, 0);
    cycle(0, 1, 6, 32'h66, 1, 7, 32'h77, 7, 6);
    cycle(0, 1, 9, 32'h99, 1, 10, 32'hA0, 7, 10);
    cycle(1, 1, 11, 32'hB1, 0, 0, 0, 7, 10);
    cycle(0, 0, 0, 0, 0, 0, 0, 7, 10);
    cycle(0, 0, 0, 0, 0, 0, 0, 7, 10);
    run_phase(600, 50, 50, 7, 5);
    run_phase(400, 100, 15, 5, 0);
    run_phase(400, 90, 90, 7, 3);
    run_phase(400, 20, 80, 31, 5);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected writes left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
